// File: rtl/fifo_sched_if.sv
// Handshake bundle for fifo_sched: two producers, the shared FIFO's ports, and the consumer.
// The slave modport is the scheduler side; master is the surrounding environment.
interface fifo_sched_if #(
  parameter int DATA_WIDTH = 24
);
  logic                  s0_valid;
  logic [DATA_WIDTH-1:0] s0_data;
  logic                  s0_ready;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_ready;
  logic                  fifo_wr;
  logic [DATA_WIDTH-1:0] fifo_w_data;
  logic                  fifo_full;
  logic                  fifo_rd;
  logic [DATA_WIDTH-1:0] fifo_r_data;
  logic                  fifo_empty;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport slave (
    input  s0_valid, s0_data, s1_valid, s1_data,
    input  fifo_full, fifo_r_data, fifo_empty, m_ready,
    output s0_ready, s1_ready, fifo_wr, fifo_w_data, fifo_rd, m_valid, m_data
  );

  modport master (
    output s0_valid, s0_data, s1_valid, s1_data,
    output fifo_full, fifo_r_data, fifo_empty, m_ready,
    input  s0_ready, s1_ready, fifo_wr, fifo_w_data, fifo_rd, m_valid, m_data
  );
endinterface

// File: rtl/fifo_sched.sv
// Round-robin write scheduler for two audio producers into a shared FIFO, plus a
// one-entry registered read stage and saturating per-channel accept counters.
module fifo_sched #(
  parameter int DATA_WIDTH = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_sched_if.slave          bus,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
  output logic                 last_grant
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                  r_prio;
  logic                  r_last_grant;
  logic [CNT_WIDTH-1:0]  r_cnt0;
  logic [CNT_WIDTH-1:0]  r_cnt1;
  logic                  r_m_valid;
  logic [DATA_WIDTH-1:0] r_m_data;

  logic w_grant0;
  logic w_grant1;
  logic w_acc0;
  logic w_acc1;
  logic w_rd;

  always_comb begin
    // NOTE: every combinational output is given a default first so no path infers a latch.
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (bus.s0_valid && bus.s1_valid) begin
      w_grant0 = ~r_prio;
      w_grant1 = r_prio;
    end else begin
      w_grant0 = bus.s0_valid;
      w_grant1 = bus.s1_valid;
    end
  end

  // Strobes are qualified by reset so nothing fires while it is held low.
  assign w_acc0 = reset & w_grant0 & ~bus.fifo_full;
  assign w_acc1 = reset & w_grant1 & ~bus.fifo_full;
  assign w_rd   = reset & ~bus.fifo_empty & (~r_m_valid | bus.m_ready);

  assign bus.s0_ready    = w_acc0;
  assign bus.s1_ready    = w_acc1;
  assign bus.fifo_wr     = w_acc0 | w_acc1;
  assign bus.fifo_w_data = w_grant1 ? bus.s1_data : bus.s0_data;
  assign bus.fifo_rd     = w_rd;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_data      = r_m_data;

  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;
  assign last_grant = r_last_grant;

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_prio       <= 1'b0;
      r_last_grant <= 1'b0;
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else begin
      if (w_acc0) begin
        r_prio       <= 1'b1;
        r_last_grant <= 1'b0;
        if (r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + CNT_ONE;
      end else if (w_acc1) begin
        r_prio       <= 1'b0;
        r_last_grant <= 1'b1;
        if (r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + CNT_ONE;
      end
    end
  end

  // A pop always reloads the stage, which also covers a same-cycle consumer take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (w_rd) begin
      r_m_valid <= 1'b1;
      r_m_data  <= bus.fifo_r_data;
    end else if (bus.m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

endmodule
